adc_pwm_source: RTL
===================

Name: adc_pwm_source

Overview:
- Upstream source for the phased-delay shift-register chain.
- Consumes ADC samples from avr_interface on one selected channel and averages them over 2^AVG_LOG2 samples.
- Drives a fixed-frequency PWM (default 40 kHz at 50 MHz) whose duty equals the averaged sample. The `pwm` output feeds the chain's `pwm_in`, replacing the external Arduino PWM.
- Duty updates are glitch-free: a new value takes effect only at a period boundary.

Parameters:
- SAMPLE_WIDTH, 10: ADC sample width.
- CTR_WIDTH, 11: period counter width.
- PERIOD, 1250: clocks per PWM period; 50 MHz / 40 kHz. Must satisfy PERIOD <= 2^CTR_WIDTH.
- AVG_LOG2, 2: log2 of the number of samples averaged (4).
- CHANNEL, 0: ADC channel accepted.

Ports:
- clk, in, 1: 50 MHz clock.
- rst_n, in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- new_sample, in, 1: one-cycle strobe; a sample is valid this cycle.
- sample, in, SAMPLE_WIDTH: ADC value.
- sample_channel, in, 4: channel of `sample`.
- enable, in, 1: run PWM; when low, output is forced low.
- pwm, out, 1: registered PWM output.
- duty, out, SAMPLE_WIDTH: compare value currently applied.
- period_start, out, 1: one-cycle pulse, aligned with the first pwm cycle of each period.

Behaviour:
- Reset values: pwm=0, duty=0, period_start=0, counter=0, accumulator=0, sample count=0, pending=0, pending_valid=0.
- Sample acceptance: a sample is accepted when new_sample=1 and sample_channel==CHANNEL. All other strobes are ignored, with no state change.
- Accumulator:
  - Width is SAMPLE_WIDTH+AVG_LOG2 bits, so it cannot overflow.
  - Each accepted sample is added and the sample count increments.
  - On the 2^AVG_LOG2-th accepted sample:
    - pending <= (acc + sample) >> AVG_LOG2, truncated.
    - pending_valid <= 1.
    - acc <= 0 and count <= 0 in the same cycle.
  - If pending_valid is already set, pending is overwritten; the latest average wins.
- Counter:
  - Runs 0..PERIOD-1 while enable=1 and wraps to 0.
  - While enable=0 it is held at 0.
- Shadow load:
  - In the cycle counter==PERIOD-1 with enable=1 and pending_valid=1: duty <= pending, and pending_valid <= 0.
  - If a new average completes in that same cycle, the load uses the old pending. The new average stays pending, with pending_valid=1, until the next wrap.
- Output:
  - pwm <= enable & (counter < duty), zero-extended compare. This gives 1 cycle of latency from the counter.
  - period_start <= enable & (counter==0). It is coincident with the first pwm cycle of a period.
- Duty range:
  - duty=0 gives pwm constantly low.
  - duty=1023 gives 1023 of 1250 high (81.8%). A 100% duty is unreachable by design.
- Enable:
  - Deassertion forces pwm=0 and period_start=0 on the next edge. The counter returns to 0.
  - Averaging continues while disabled. duty is not loaded while disabled.
  - Reassertion starts a full period from counter 0.
- Reset asserted mid-operation clears every register immediately, asynchronously. A partial average is discarded.

Decomposition:
- Shared package pwm_pkg contains:
  - ADC_WIDTH=10.
  - CLK_HZ=50_000_000.
  - PWM_HZ=40_000.
  - PWM_PERIOD=1250.
  - ADC_CH_A0=4'd0.
- One sub-module, sample_averager. It handles channel filtering, the accumulator and count, and produces pending/pending_valid with a clear input driven by the shadow load.
- Counter, shadow register and output stay in adc_pwm_source.

Test Plan:
- Averaging: with enable=1, feed channel-0 samples 100, 200, 300, 400.
  - Required: after the next wrap, duty=250.
  - Required: pwm is high for exactly 250 clocks of each 1250.
  - Required: period_start pulses every 1250 clocks.
- Channel filter: interleave channel-3 samples of 1023 with channel-0 samples of 8, 8, 8, 8.
  - Required: duty=8; the channel-3 samples are ignored.
- Glitch-free update: average completes at counter 600.
  - Required: the current period keeps the old duty.
  - Required: the new duty applies starting at the period_start after counter 1249.
- Simultaneous events: average A pending, then average B completes in the counter==1249 cycle.
  - Required: A loads at this wrap, and B loads one period later.
- Enable and extremes: enable low for 3000 clocks.
  - Required: pwm=0 and no period_start.
  - Required: after reassertion, the first period_start appears 1 clock after enable rises.
  - Required: duty=0 gives pwm never high; duty=1023 gives 1023 high per period.
- Reset mid-average: three samples of 400 accepted, then rst_n pulsed low, then four samples of 40.
  - Required: duty=40; the partial sum is discarded.
  - Required: all outputs read 0 during reset.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared constants for the ADC-driven PWM source that feeds the
//   phased-delay shift-register chain.
//   ADC_WIDTH  : width of one avr_interface ADC sample
//   CLK_HZ     : system clock frequency
//   PWM_HZ     : PWM carrier frequency
//   PWM_PERIOD : clocks per PWM period (CLK_HZ / PWM_HZ)
//   ADC_CH_A0  : ADC channel code for analog input A0
package pwm_pkg;

    localparam int          ADC_WIDTH  = 10;
    localparam int          CLK_HZ     = 50_000_000;
    localparam int          PWM_HZ     = 40_000;
    localparam int          PWM_PERIOD = CLK_HZ / PWM_HZ;
    localparam logic [3:0]  ADC_CH_A0  = 4'd0;

endpackage

// File: rtl/adc_pwm_source_averager.sv
// sample_averager
//   Accepts ADC samples on one channel, sums 2^AVG_LOG2 of them and
//   publishes the truncated mean as a pending duty value.
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   new_sample     : one-cycle strobe, sample valid this cycle
//   sample         : ADC value
//   sample_channel : channel that produced sample
//   clear          : consumer has taken pending, drop pending_valid
//   pending        : most recent completed average
//   pending_valid  : pending holds an average not yet consumed
module sample_averager
    import pwm_pkg::*;
#(
    parameter int SAMPLE_WIDTH = ADC_WIDTH,
    parameter int AVG_LOG2     = 2,
    parameter int CHANNEL      = int'(ADC_CH_A0)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    new_sample,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [3:0]              sample_channel,
    input  logic                    clear,
    output logic [SAMPLE_WIDTH-1:0] pending,
    output logic                    pending_valid
);

    // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    localparam int ACC_W = SAMPLE_WIDTH + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic                    accept;
    logic [ACC_W-1:0]        sum;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [SAMPLE_WIDTH-1:0] pending_q, pending_d;
    logic                    valid_q, valid_d;

    always_comb begin
        accept    = new_sample && (sample_channel == 4'(CHANNEL));
        sum       = acc_q + ACC_W'(sample);
        acc_d     = acc_q;
        count_d   = count_q;
        pending_d = pending_q;
        valid_d   = valid_q;

        if (clear) begin
            valid_d = 1'b0;
        end

        // A completing average overrides a same-cycle clear: the consumer
        // took the old value, the new one must stay pending.
        if (accept) begin
            if (count_q == LAST_COUNT) begin
                pending_d = SAMPLE_WIDTH'(sum >> AVG_LOG2);
                valid_d   = 1'b1;
                acc_d     = '0;
                count_d   = '0;
            end else begin
                acc_d   = sum;
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            count_q   <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
        end
    end

    assign pending       = pending_q;
    assign pending_valid = valid_q;

endmodule

// File: rtl/adc_pwm_source.sv
// adc_pwm_source
//   Fixed-frequency PWM whose duty tracks an averaged ADC channel. Its
//   pwm output replaces the external PWM at the head of the phased-delay
//   chain. New duty values are only applied at period boundaries.
//   clk            : system clock (50 MHz)
//   rst_n          : asynchronous active-low reset
//   new_sample     : one-cycle ADC sample strobe
//   sample         : ADC value
//   sample_channel : channel of sample
//   enable         : run the PWM; low forces pwm low and parks the counter
//   pwm            : registered PWM output
//   duty           : compare value currently applied
//   period_start   : one-cycle pulse with the first pwm cycle of a period
module adc_pwm_source
    import pwm_pkg::*;
#(
    parameter int SAMPLE_WIDTH = ADC_WIDTH,
    parameter int CTR_WIDTH    = 11,
    parameter int PERIOD       = PWM_PERIOD,
    parameter int AVG_LOG2     = 2,
    parameter int CHANNEL      = int'(ADC_CH_A0)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    new_sample,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [3:0]              sample_channel,
    input  logic                    enable,
    output logic                    pwm,
    output logic [SAMPLE_WIDTH-1:0] duty,
    output logic                    period_start
);

    localparam int CMP_W = (CTR_WIDTH > SAMPLE_WIDTH) ? CTR_WIDTH : SAMPLE_WIDTH;
    localparam logic [CTR_WIDTH-1:0] LAST_TICK = CTR_WIDTH'(PERIOD - 1);

    logic [SAMPLE_WIDTH-1:0] pending;
    logic                    pending_valid;
    logic                    at_end;
    logic                    load;

    logic [CTR_WIDTH-1:0]    counter_q, counter_d;
    logic [SAMPLE_WIDTH-1:0] duty_q, duty_d;
    logic                    pwm_q, pwm_d;
    logic                    start_q, start_d;

    sample_averager #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .AVG_LOG2     (AVG_LOG2),
        .CHANNEL      (CHANNEL)
    ) u_averager (
        .clk            (clk),
        .rst_n          (rst_n),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .clear          (load),
        .pending        (pending),
        .pending_valid  (pending_valid)
    );

    always_comb begin
        at_end = (counter_q == LAST_TICK);

        // Counter parks at 0 while disabled so re-enable starts a full period.
        counter_d = '0;
        if (enable && !at_end) begin
            counter_d = counter_q + 1'b1;
        end

        // Shadow load only on the last tick, so a period never mixes duties.
        load   = enable && at_end && pending_valid;
        duty_d = load ? pending : duty_q;

        pwm_d   = enable && (CMP_W'(counter_q) < CMP_W'(duty_q));
        start_d = enable && (counter_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            counter_q <= counter_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            start_q   <= start_d;
        end
    end

    assign pwm          = pwm_q;
    assign duty         = duty_q;
    assign period_start = start_q;

endmodule
